// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response handshake and data-memory port of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine with lane extraction,
// sign extension and read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int MEM_IDX_W = 10
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t                 state, state_nx;
    logic [MEM_IDX_W+1:0]   addr_q;
    logic [31:0]            wdata_q, word_q, mask, ld;
    logic [15:0]            lane;
    logic [4:0]             sh;
    logic [1:0]             size_q;
    logic                   uns_q, we_q, err_q, hs, mis;
    assign hs  = bus.req_valid & bus.req_ready;
    assign mis = (bus.req_size == 2'd3) | (bus.req_size == 2'd1 & bus.req_addr[0]) |
                 (bus.req_size == 2'd2 & |bus.req_addr[1:0]);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (hs) begin
                addr_q  <= bus.req_addr[MEM_IDX_W+1:0];
                wdata_q <= bus.req_wdata;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                we_q    <= bus.req_we;
                err_q   <= mis;
            end
            if (state == RD) word_q <= bus.mem_rd;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (hs) state_nx = mis ? RESP : (bus.req_we && bus.req_size == 2'd2) ? WR : RD;
            RD:      state_nx = we_q ? WR : RESP;
            WR:      state_nx = RESP;
            default: if (bus.resp_ready) state_nx = IDLE;
        endcase
    end
    // Lane shift works for halves too because only aligned halves reach here.
    assign sh   = {addr_q[1:0], 3'b000};
    assign lane = 16'(word_q >> sh);
    assign mask = (size_q == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    assign ld   = size_q == 2'd0 ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
                  size_q == 2'd1 ? {{16{~uns_q & lane[15]}}, lane} : word_q;
    assign bus.req_ready  = rst & (state == IDLE);
    assign bus.resp_valid = state == RESP;
    assign bus.resp_err   = (state == RESP) & err_q;
    assign bus.resp_rdata = (state == RESP && !we_q && !err_q) ? ld : '0;
    assign bus.mem_we     = state == WR;
    assign bus.mem_a      = {{(32-MEM_IDX_W){1'b0}}, addr_q[MEM_IDX_W+1:2]};
    assign bus.mem_wd     = size_q == 2'd2 ? wdata_q : (word_q & ~mask) | ((wdata_q << sh) & mask);
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized check of load_store_unit against a byte-addressed reference memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    load_store_unit_if bus();
    load_store_unit #(.MEM_IDX_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [31:0] mem [1024];
    logic [7:0]  ref_b [4096];
    int tests = 0;
    int fails = 0;
    int o_lat, o_we_cnt;
    logic [31:0] o_rdata, o_we_a, o_we_wd;
    logic o_err, o_we_first;
    assign bus.mem_rd = mem[bus.mem_a[9:0]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[9:0]] = bus.mem_wd;

    function automatic logic [31:0] m_load(logic [31:0] a, logic [1:0] s, logic u);
        int n = 1 << s;
        int base = int'(a[11:0]);
        logic [31:0] v = 0;
        for (int k = 0; k < n; k++) v |= 32'(ref_b[(base + k) % 4096]) << (8 * k);
        if (!u && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction
    function automatic logic m_err(logic [31:0] a, logic [1:0] s);
        return s == 2'd3 || (int'(a[1:0]) % (1 << s)) != 0;
    endfunction
    function automatic int m_lat(logic we, logic [31:0] a, logic [1:0] s);
        if (m_err(a, s)) return 1;
        return (we && s != 2'd2) ? 3 : 2;
    endfunction
    task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int base = int'(a[11:0]);
        for (int k = 0; k < (1 << s); k++) ref_b[(base + k) % 4096] = 8'(d >> (8 * k));
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd);
        int w = 0;
        while (!bus.req_ready && w < 10) begin @(posedge clk); #1; w++; end
        bus.req_valid = 1; bus.req_we = we; bus.req_addr = addr;
        bus.req_size = size; bus.req_unsigned = uns; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 0;
        o_lat = 1; o_we_cnt = 0; o_we_first = bus.mem_we; o_we_a = 0; o_we_wd = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.mem_we) begin o_we_cnt++; o_we_a = bus.mem_a; o_we_wd = bus.mem_wd; end
            if (bus.resp_valid) break;
            @(posedge clk); #1;
            o_lat++;
        end
        if (!bus.resp_valid) o_lat = 99;
        o_rdata = bus.resp_rdata;
        o_err = bus.resp_err;
    endtask
    task automatic complete();
        bus.resp_ready = 1;
        @(posedge clk); #1;
        bus.resp_ready = 0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_we} !== 4'b0 ||
            bus.resp_rdata !== 0 || bus.mem_a !== 0 || bus.mem_wd !== 0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b vld=%b err=%b we=%b rdata=%h a=%h wd=%h, want all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_we, bus.resp_rdata, bus.mem_a, bus.mem_wd);
        end
        @(negedge clk); rst = 1; #1;
        tests++;
        if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_spec_vectors();
        issue(0, 32'h1C, 2'd0, 0, 0);
        tests++; if (o_rdata !== 32'hFFFFFF80) begin fails++; $display("FAIL sb_load_data: got %h want FFFFFF80", o_rdata); end
        tests++; if (o_err !== 1'b0 || o_lat !== 2) begin fails++; $display("FAIL sb_load_lat: err %b lat %0d want 0/2", o_err, o_lat); end
        complete();
        issue(0, 32'h1E, 2'd1, 1, 0);
        tests++; if (o_rdata !== 32'h00008001) begin fails++; $display("FAIL uh_load_data: got %h want 00008001", o_rdata); end
        complete();
        issue(1, 32'h1D, 2'd0, 0, 32'hAB);
        m_store(32'h1D, 2'd0, 32'hAB);
        tests++; if (o_lat !== 3 || o_we_cnt !== 1 || o_we_first !== 1'b0) begin
            fails++; $display("FAIL sb_store_timing: lat %0d we_cycles %0d rd_we %b want 3/1/0", o_lat, o_we_cnt, o_we_first); end
        tests++; if (o_we_a !== 32'd7 || o_we_wd !== 32'h8001AB80) begin
            fails++; $display("FAIL sb_store_write: a %h wd %h want 7/8001AB80", o_we_a, o_we_wd); end
        tests++; if (o_rdata !== 0 || o_err !== 0) begin fails++; $display("FAIL sb_store_resp: rdata %h err %b want 0/0", o_rdata, o_err); end
        complete();
        issue(0, 32'h1E, 2'd2, 0, 0);
        tests++; if (o_err !== 1'b1 || o_rdata !== 0 || o_we_cnt !== 0 || o_lat !== 1) begin
            fails++; $display("FAIL misaligned_word: err %b rdata %h we %0d lat %0d want 1/0/0/1", o_err, o_rdata, o_we_cnt, o_lat); end
        complete();
        issue(0, 32'h1C, 2'd2, 0, 0);
        tests++; if (o_rdata !== 32'h8001AB80 || o_rdata !== m_load(32'h1C, 2'd2, 0)) begin
            fails++; $display("FAIL word_after_store: got %h want 8001AB80", o_rdata); end
        complete();
    endtask

    task automatic test_backpressure();
        logic [31:0] a, r0;
        logic bad = 0;
        a = {$urandom_range(0, 1023), 2'b00};
        issue(0, a, 2'd2, 0, 0);
        r0 = o_rdata;
        tests++; if (r0 !== m_load(a, 2'd2, 0)) begin fails++; $display("FAIL bp_data: got %h want %h", r0, m_load(a, 2'd2, 0)); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== r0 || bus.req_ready !== 1'b0) bad = 1;
        end
        tests++; if (bad) begin fails++; $display("FAIL bp_hold: vld %b rdata %h rdy %b want 1/%h/0", bus.resp_valid, bus.resp_rdata, bus.req_ready, r0); end
        complete();
        tests++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release: vld %b rdy %b want 0/1", bus.resp_valid, bus.req_ready); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, er;
        logic [1:0] s;
        logic we, u, e, held;
        int bad_words = 0;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3)); a = $urandom; d = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = s == 2'd0 ? a[1:0] : s == 2'd1 ? {a[1], 1'b0} : 2'b00;
            e = m_err(a, s);
            er = (!we && !e) ? m_load(a, s, u) : 32'd0;
            issue(we, a, s, u, d);
            tests++; if (o_rdata !== er || o_err !== e) begin
                fails++; $display("FAIL rand_resp #%0d: rdata %h err %b want %h/%b", n, o_rdata, o_err, er, e); end
            tests++; if (o_lat !== m_lat(we, a, s) || o_we_cnt !== int'(we && !e)) begin
                fails++; $display("FAIL rand_timing #%0d: lat %0d we %0d want %0d/%0d", n, o_lat, o_we_cnt, m_lat(we, a, s), int'(we && !e)); end
            held = 1;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== er || bus.resp_err !== e) held = 0;
            end
            tests++; if (!held) begin fails++; $display("FAIL rand_hold #%0d: rdata %h want %h", n, bus.resp_rdata, er); end
            if (we && !e) m_store(a, s, d);
            complete();
        end
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]}) bad_words++;
        tests++; if (bad_words != 0) begin fails++; $display("FAIL rand_memory: %0d words differ, want 0", bad_words); end
    endtask

    task automatic test_reset_in_wr();
        logic [31:0] old;
        logic bad = 0;
        old = m_load(32'h40, 2'd2, 0);
        bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h40;
        bus.req_size = 2'd2; bus.req_unsigned = 0; bus.req_wdata = ~old;
        @(posedge clk); #1;
        bus.req_valid = 0;
        tests++; if (bus.mem_we !== 1'b1) begin fails++; $display("FAIL rwr_in_wr: mem_we %b want 1", bus.mem_we); end
        #2 rst = 0; #1;
        tests++; if (bus.mem_we !== 1'b0 || bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            fails++; $display("FAIL rwr_async: we %b rdy %b vld %b want 0/0/0", bus.mem_we, bus.req_ready, bus.resp_valid); end
        @(posedge clk); @(negedge clk); rst = 1;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) bad = 1;
        end
        tests++; if (bad) begin fails++; $display("FAIL rwr_no_resp: vld %b rdy %b want 0/1", bus.resp_valid, bus.req_ready); end
        issue(0, 32'h40, 2'd2, 0, 0);
        tests++; if (o_rdata !== old) begin fails++; $display("FAIL rwr_dropped: got %h want %h", o_rdata, old); end
        complete();
    endtask

    task automatic test_wrap();
        issue(1, 32'hFFFFF010, 2'd2, 0, 32'hDEADBEEF);
        m_store(32'hFFFFF010, 2'd2, 32'hDEADBEEF);
        tests++; if (o_we_a !== 32'd4 || o_we_wd !== 32'hDEADBEEF || o_lat !== 2) begin
            fails++; $display("FAIL wrap_store: a %h wd %h lat %0d want 4/DEADBEEF/2", o_we_a, o_we_wd, o_lat); end
        complete();
        issue(0, 32'h00000012, 2'd1, 0, 0);
        tests++; if (o_rdata !== 32'hFFFFDEAD) begin fails++; $display("FAIL wrap_load: got %h want FFFFDEAD", o_rdata); end
        complete();
    endtask

    initial begin
        logic [31:0] w;
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_size = 0;
        bus.req_unsigned = 0; bus.req_wdata = 0; bus.resp_ready = 0;
        for (int i = 0; i < 1024; i++) begin
            w = (i == 7) ? 32'h8001FF80 : $urandom;
            mem[i] = w;
            for (int k = 0; k < 4; k++) ref_b[4*i+k] = 8'(w >> (8 * k));
        end
        test_reset();
        test_spec_vectors();
        test_backpressure();
        test_random();
        test_reset_in_wr();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
